// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus of the bit-serial add/subtract sequencer.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  // Requester side: issues operations and observes completion
  modport master (
    output start, a, b, sub,
    input  ready, busy, done, result, cout, overflow
  );

  // Engine side: accepts operations and reports results
  modport slave (
    input  start, a, b, sub,
    output ready, busy, done, result, cout, overflow
  );

endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full-adder cell, LSB first,
// one bit per clock, WIDTH+2 cycles per operation including IDLE and DONE.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  logic             sum_bit;
  logic             cell_cout;
  logic [WIDTH-1:0] r_next;

  // Shared 1-bit full-adder cell and the result register after this cycle's shift
  assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign cell_cout = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign r_next    = {sum_bit, r_sr[WIDTH-1:1]};

  // Sequencer: state, datapath registers and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1
            a_sr  <= bus.a;
            b_sr  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          r_sr  <= r_next;
          carry <= cell_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Last bit: carry flop still holds the carry into the MSB
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= r_next;
            cout     <= cell_cout;
            overflow <= carry ^ cell_cout;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.result   = result;
  assign bus.cout     = cout;
  assign bus.overflow = overflow;

endmodule
